// File: rtl/open_ctrl_pkg.sv
// Shared door package: controller state encoding and default timing constants.
// The downstream close stage imports the same definitions.
package open_ctrl_pkg;

  localparam int OPEN_TIME_DEF = 8;
  localparam int HOLD_TIME_DEF = 100;
  localparam int PULSE_LEN_DEF = 4;
  localparam int CLOSE_TMO_DEF = 63;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    OPENING    = 3'd1,
    HOLD       = 3'd2,
    PROMPT     = 3'd3,
    WAIT_CLOSE = 3'd4
  } state_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector built on a registered copy of the input.
// Each pulse is high for the single cycle in which the input differs from the registered copy.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/open_ctrl.sv
// Door-open controller: open pulse, hold dwell, close prompt, then wait for the close stage.
// Every output is registered from the next-state decode, so outputs and state always agree.
module open_ctrl
  import open_ctrl_pkg::*;
#(
  parameter int OPEN_TIME = OPEN_TIME_DEF,
  parameter int HOLD_TIME = HOLD_TIME_DEF,
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int CLOSE_TMO = CLOSE_TMO_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arrive,
  input  logic   r,
  input  logic   close_signal,
  output logic   open_signal,
  output logic   c_100,
  output logic   busy,
  output logic   fault,
  output state_t state_dbg
);

  localparam int HW = $clog2(HOLD_TIME + 1);
  localparam int CW = $clog2(max_of3(OPEN_TIME, PULSE_LEN, CLOSE_TMO) + 1);

  state_t        state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          seen_rise, seen_d;
  logic          fault_d;
  logic          close_rise, close_fall;

  edge_det u_close_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (close_signal),
    .rise (close_rise),
    .fall (close_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cnt         <= '0;
      seen_rise   <= 1'b0;
      open_signal <= 1'b0;
      c_100       <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      cnt         <= cnt_d;
      seen_rise   <= seen_d;
      open_signal <= (state_d == OPENING);
      c_100       <= (state_d == PROMPT);
      busy        <= (state_d != IDLE);
      fault       <= fault_d;
    end
  end

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    cnt_d   = cnt;
    seen_d  = seen_rise;
    fault_d = 1'b0;
    case (state)
      IDLE: begin
        hold_d = '0;
        cnt_d  = '0;
        seen_d = 1'b0;
        if (arrive || r) state_d = OPENING;
      end
      OPENING: begin
        if (cnt == CW'(OPEN_TIME - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (r) begin
          hold_d = '0;
        end else if (hold_cnt == HW'(HOLD_TIME - 1)) begin
          state_d = PROMPT;
          hold_d  = '0;
          cnt_d   = '0;
        end else begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      PROMPT: begin
        // A press restarts the pulse, so the prompt never ends early.
        if (r) begin
          cnt_d = '0;
        end else if (cnt == CW'(PULSE_LEN - 1)) begin
          state_d = WAIT_CLOSE;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT_CLOSE: begin
        // cnt parks at CLOSE_TMO for the single cycle fault is high.
        if (r) begin
          state_d = OPENING;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end else if (cnt == CW'(CLOSE_TMO)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (seen_rise && close_fall) begin
          state_d = IDLE;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end else if (!seen_rise) begin
          if (close_rise) begin
            seen_d = 1'b1;
          end else if (cnt == CW'(CLOSE_TMO - 1)) begin
            cnt_d   = CW'(CLOSE_TMO);
            fault_d = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_open_ctrl.sv
// Scoreboard bench for open_ctrl: each scenario queues per-cycle stimulus and the
// expected {open_signal, c_100, busy, fault} vector, then replays and compares cycle by cycle.
module tb_open_ctrl;
  import open_ctrl_pkg::*;

  localparam logic [3:0] V_IDLE   = 4'b0000;
  localparam logic [3:0] V_OPEN   = 4'b1010;
  localparam logic [3:0] V_BUSY   = 4'b0010;
  localparam logic [3:0] V_PROMPT = 4'b0110;
  localparam logic [3:0] V_FAULT  = 4'b0011;

  logic   clk = 1'b0;
  logic   rst, arrive, r, close_signal;
  logic   open_signal, c_100, busy, fault;
  state_t state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] stim_q[$];
  logic [3:0] exp_q[$];

  open_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .arrive       (arrive),
    .r            (r),
    .close_signal (close_signal),
    .open_signal  (open_signal),
    .c_100        (c_100),
    .busy         (busy),
    .fault        (fault),
    .state_dbg    (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver helpers: {arrive, r, close_signal} per cycle
  task automatic stim(input int n, input logic a, input logic rr, input logic c);
    repeat (n) stim_q.push_back({a, rr, c});
  endtask

  task automatic expect_out(input int n, input logic [3:0] v);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic play(input string name);
    int i;
    logic [2:0] s;
    logic [3:0] e;
    i = 0;
    while (exp_q.size() > 0) begin
      s = (stim_q.size() > 0) ? stim_q.pop_front() : 3'b000;
      e = exp_q.pop_front();
      @(posedge clk);
      #1 {arrive, r, close_signal} = s;
      @(negedge clk);
      check_val($sformatf("%s_c%0d", name, i),
                {28'd0, open_signal, c_100, busy, fault}, {28'd0, e});
      i++;
    end
    stim_q.delete();
  endtask

  // Full door cycle with an r press at HOLD count k (k < 0: no press).
  task automatic door_cycle(input string name, input int k);
    stim(1, 1'b1, 1'b0, 1'b0);
    if (k >= 0) begin
      stim(8 + k, 1'b0, 1'b0, 1'b0);
      stim(1, 1'b0, 1'b1, 1'b0);
      stim(105, 1'b0, 1'b0, 1'b0);
    end else begin
      stim(113, 1'b0, 1'b0, 1'b0);
    end
    stim(2, 1'b0, 1'b0, 1'b1);
    stim(5, 1'b0, 1'b0, 1'b0);
    expect_out(1, V_IDLE);
    expect_out(8, V_OPEN);
    expect_out((k >= 0) ? 101 + k : 100, V_BUSY);
    expect_out(4, V_PROMPT);
    expect_out(4, V_BUSY);
    expect_out(4, V_IDLE);
    play(name);
  endtask

  task automatic check_all_low(input string tag);
    check_val({tag, "_open"},  {31'd0, open_signal}, 32'd0);
    check_val({tag, "_c100"},  {31'd0, c_100},       32'd0);
    check_val({tag, "_busy"},  {31'd0, busy},        32'd0);
    check_val({tag, "_fault"}, {31'd0, fault},       32'd0);
    check_val({tag, "_state"}, 32'(state_dbg),       32'(IDLE));
  endtask

  initial begin
    rst = 1'b0; arrive = 1'b0; r = 1'b0; close_signal = 1'b0;
    #1 rst = 1'b1;
    #2 check_all_low("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic cycle: open 8, hold 100, prompt 4, close rise/fall
    door_cycle("basic", -1);

    // r at hold count 50, then random press points
    door_cycle("hold_r50", 50);
    for (int t = 0; t < 3; t++) door_cycle($sformatf("hold_rnd%0d", t), int'($urandom_range(0, 99)));

    // r held 3 cycles in PROMPT stretches the prompt
    stim(1, 1'b1, 1'b0, 1'b0);
    stim(109, 1'b0, 1'b0, 1'b0);
    stim(3, 1'b0, 1'b1, 1'b0);
    stim(5, 1'b0, 1'b0, 1'b0);
    stim(2, 1'b0, 1'b0, 1'b1);
    stim(5, 1'b0, 1'b0, 1'b0);
    expect_out(1, V_IDLE);
    expect_out(8, V_OPEN);
    expect_out(100, V_BUSY);
    expect_out(8, V_PROMPT);
    expect_out(4, V_BUSY);
    expect_out(4, V_IDLE);
    play("prompt_r");

    // close held 32 cycles, r on the 10th -> reopen, full cycle again
    stim(1, 1'b1, 1'b0, 1'b0);
    stim(112, 1'b0, 1'b0, 1'b0);
    stim(9, 1'b0, 1'b0, 1'b1);
    stim(1, 1'b0, 1'b1, 1'b1);
    stim(22, 1'b0, 1'b0, 1'b1);
    stim(91, 1'b0, 1'b0, 1'b0);
    stim(2, 1'b0, 1'b0, 1'b1);
    stim(5, 1'b0, 1'b0, 1'b0);
    expect_out(1, V_IDLE);
    expect_out(8, V_OPEN);
    expect_out(100, V_BUSY);
    expect_out(4, V_PROMPT);
    expect_out(10, V_BUSY);
    expect_out(8, V_OPEN);
    expect_out(100, V_BUSY);
    expect_out(4, V_PROMPT);
    expect_out(4, V_BUSY);
    expect_out(4, V_IDLE);
    play("reopen");

    // arrive+r together open once; arrive while busy ignored; no close -> fault
    stim(1, 1'b1, 1'b1, 1'b0);
    stim(49, 1'b0, 1'b0, 1'b0);
    stim(3, 1'b1, 1'b0, 1'b0);
    stim(128, 1'b0, 1'b0, 1'b0);
    expect_out(1, V_IDLE);
    expect_out(8, V_OPEN);
    expect_out(100, V_BUSY);
    expect_out(4, V_PROMPT);
    expect_out(63, V_BUSY);
    expect_out(1, V_FAULT);
    expect_out(4, V_IDLE);
    play("timeout");

    // async reset mid-HOLD, then a fresh arrive is needed
    stim(1, 1'b1, 1'b0, 1'b0);
    stim(29, 1'b0, 1'b0, 1'b0);
    expect_out(1, V_IDLE);
    expect_out(8, V_OPEN);
    expect_out(21, V_BUSY);
    play("pre_rst");
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_low("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stim(5, 1'b0, 1'b0, 1'b0);
    stim(1, 1'b1, 1'b0, 1'b0);
    stim(3, 1'b0, 1'b0, 1'b0);
    expect_out(6, V_IDLE);
    expect_out(3, V_OPEN);
    play("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
